// File: rtl/neighbor_reader.sv
// Walks the neighbor-list RAM and streams (vertex, neighbor) pairs
// over a valid/ready handshake; read-only master of the NBR RAM.
module neighbor_reader #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_NBR_EN,
    output logic [3:0]            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_vertex,
    output logic [31:0]           out_neighbor,
    output logic [3:0]            out_count,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overflow
);

    localparam logic [3:0] CMAX = 4'(MAX_NEIGHBOR_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_CNT,
        S_WAIT_CNT,
        S_ADDR_NBR,
        S_WAIT_NBR,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [31:0]           v_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [3:0]            cnt_q;
    logic [3:0]            k_q;
    logic                  en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  valid_q;
    logic [31:0]           ov_vertex_q;
    logic [31:0]           ov_nbr_q;
    logic [3:0]            ov_count_q;
    logic                  ov_last_q;
    logic                  busy_q;
    logic                  ovf_q;

    // The RAM is never written; its write port is tied off.
    assign RAM_NBR_WE   = 4'b0000;
    assign RAM_NBR_Di   = 32'd0;
    assign RAM_NBR_EN   = en_q;
    assign RAM_NBR_A    = addr_q;
    assign out_valid    = valid_q;
    assign out_vertex   = ov_vertex_q;
    assign out_neighbor = ov_nbr_q;
    assign out_count    = ov_count_q;
    assign out_last     = ov_last_q;
    assign busy         = busy_q;
    assign overflow     = ovf_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            v_q         <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            en_q        <= 1'b0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            ov_vertex_q <= '0;
            ov_nbr_q    <= '0;
            ov_count_q  <= '0;
            ov_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        en_q    <= 1'b1;
                        v_q     <= 32'd1;
                        base_q  <= '0;
                        state_q <= (vertex_count == 32'd0) ? S_DONE : S_ADDR_CNT;
                    end
                end
                S_ADDR_CNT: begin
                    addr_q  <= base_q;
                    state_q <= S_WAIT_CNT;
                end
                S_WAIT_CNT: begin
                    if (RAM_NBR_Do[3:0] > CMAX) begin
                        cnt_q <= CMAX;
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= RAM_NBR_Do[3:0];
                    end
                    if (RAM_NBR_Do[3:0] == 4'd0) begin
                        ov_vertex_q <= v_q;
                        ov_nbr_q    <= '0;
                        ov_count_q  <= '0;
                        ov_last_q   <= 1'b1;
                        valid_q     <= 1'b1;
                        state_q     <= S_EMIT;
                    end else begin
                        k_q     <= 4'd1;
                        state_q <= S_ADDR_NBR;
                    end
                end
                S_ADDR_NBR: begin
                    addr_q  <= base_q + ADDR_WIDTH'(k_q);
                    state_q <= S_WAIT_NBR;
                end
                S_WAIT_NBR: begin
                    ov_vertex_q <= v_q;
                    ov_nbr_q    <= RAM_NBR_Do;
                    ov_count_q  <= cnt_q;
                    ov_last_q   <= (k_q == cnt_q);
                    valid_q     <= 1'b1;
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (!ov_last_q) begin
                            k_q     <= k_q + 4'd1;
                            state_q <= S_ADDR_NBR;
                        end else if (v_q < vertex_count) begin
                            v_q     <= v_q + 32'd1;
                            base_q  <= base_q + STRIDE;
                            state_q <= S_ADDR_CNT;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_reader.sv
// Scoreboard bench for neighbor_reader: random RAM contents and
// consumer back-pressure against a list-walking reference model.
module tb_neighbor_reader;

    typedef struct packed {
        logic [31:0] v;
        logic [31:0] n;
        logic [3:0]  c;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] vertex_count = '0;
    logic [31:0] RAM_NBR_Do = '0;
    logic        RAM_NBR_EN;
    logic [3:0]  RAM_NBR_WE;
    logic [8:0]  RAM_NBR_A;
    logic [31:0] RAM_NBR_Di;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_vertex;
    logic [31:0] out_neighbor;
    logic [3:0]  out_count;
    logic        out_last;
    logic        busy;
    logic        overflow;

    logic [31:0] mem [512];
    beat_t       exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          rdy_pct = 100;

    neighbor_reader #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(9)) dut (
        .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count),
        .RAM_NBR_Do(RAM_NBR_Do), .RAM_NBR_EN(RAM_NBR_EN),
        .RAM_NBR_WE(RAM_NBR_WE), .RAM_NBR_A(RAM_NBR_A),
        .RAM_NBR_Di(RAM_NBR_Di), .out_valid(out_valid),
        .out_ready(out_ready), .out_vertex(out_vertex),
        .out_neighbor(out_neighbor), .out_count(out_count),
        .out_last(out_last), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data one clock after the address.
    always @(posedge clk)
        if (RAM_NBR_EN) RAM_NBR_Do <= mem[RAM_NBR_A];

    always @(posedge clk) begin
        #1 out_ready = ($urandom_range(0, 99) < rdy_pct);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: handshake is decided at the next negedge with these values.
    beat_t held_b;
    logic [8:0] held_a;
    bit    held = 1'b0;
    always @(posedge clk) begin
        beat_t cur;
        beat_t e;
        #2;
        cur = '{out_vertex, out_neighbor, out_count, out_last};
        if (rst) begin
            held = 1'b0;
        end else begin
            chk("we_zero", 64'(RAM_NBR_WE), 64'd0);
            if (out_valid && !busy) chk("valid_outside_busy", 64'd1, 64'd0);
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_beat", 64'(cur), 64'(held_b));
                chk("hold_addr", 64'(RAM_NBR_A), 64'(held_a));
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(cur), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL beat actual v=%0d n=%0h c=%0d l=%0d required v=%0d n=%0h c=%0d l=%0d",
                                 cur.v, cur.n, cur.c, cur.l, e.v, e.n, e.c, e.l);
                    end
                end
            end else if (out_valid) begin
                held   = 1'b1;
                held_b = cur;
                held_a = RAM_NBR_A;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Reference: walk each vertex's list straight out of the RAM image.
    function automatic bit model(input int n);
        bit ov = 1'b0;
        for (int v = 1; v <= n; v++) begin
            int    base = ((v - 1) * 10) % 512;
            int    c = int'(mem[base] & 32'hF);
            beat_t b;
            if (c > 9) begin
                c = 9;
                ov = 1'b1;
            end
            if (c == 0) begin
                b = '{32'(v), 32'd0, 4'd0, 1'b1};
                exp_q.push_back(b);
            end else begin
                for (int k = 1; k <= c; k++) begin
                    b = '{32'(v), mem[(base + k) % 512], 4'(c), k == c};
                    exp_q.push_back(b);
                end
            end
        end
        return ov;
    endfunction

    task automatic run(input int n, input bit hold, input bit poke,
                       output int lat, output int bcyc);
        bit eov;
        int i;
        int hc;
        int saved;
        saved = rdy_pct;
        vertex_count = 32'(n);
        eov = model(n);
        if (hold) rdy_pct = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #1;
        lat = -1;
        bcyc = busy ? 1 : 0;
        i = 0;
        hc = -1;
        while (busy && i < 20000) begin
            @(posedge clk);
            #1 start = poke && (i == 10);
            #1;
            i++;
            if (out_valid && lat < 0) begin
                lat = i;
                if (hold) hc = 5;
            end else if (hc > 0) begin
                hc--;
                if (hc == 0) rdy_pct = saved;
            end
            if (busy) bcyc++;
        end
        start = 1'b0;
        rdy_pct = saved;
        if (i >= 20000) chk("busy_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("overflow", 64'(overflow), 64'(eov));
        chk("busy_low", 64'(busy), 64'd0);
        chk("en_low", 64'(RAM_NBR_EN), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int lat;
        int bcyc;
        int w;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_en", 64'(RAM_NBR_EN), 64'd0);
        chk("rst_addr", 64'(RAM_NBR_A), 64'd0);
        chk("rst_beat", 64'({out_vertex, out_neighbor, out_count, out_last}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;

        // Two-vertex example list
        mem[0] = 32'd2; mem[1] = 32'd2; mem[2] = 32'd3;
        mem[10] = 32'd1; mem[11] = 32'd1;
        rdy_pct = 100;
        run(2, 1'b0, 1'b0, lat, bcyc);
        chk("first_latency", 64'(lat), 64'd4);
        chk("busy_cycles_ex", 64'(bcyc), 64'd14);

        // Empty list then one neighbor
        mem[0] = 32'hABCD_0000; mem[10] = 32'd1; mem[11] = 32'd77;
        run(2, 1'b0, 1'b0, lat, bcyc);

        // Count word 10 clamps to 9 and sets overflow
        mem[0] = 32'd10;
        for (int k = 1; k < 10; k++) mem[k] = 32'(100 + k);
        run(1, 1'b0, 1'b0, lat, bcyc);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Back-pressure held for 5 cycles; overflow cleared by new start
        mem[0] = 32'd3;
        run(1, 1'b1, 1'b0, lat, bcyc);

        // Zero vertices
        run(0, 1'b0, 1'b0, lat, bcyc);
        chk("zero_busy_cycles", 64'(bcyc), 64'd1);
        chk("zero_no_valid", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset while a beat is held
        rdy_pct = 0;
        vertex_count = 32'd2;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk);
            #2;
            w++;
        end
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_addr", 64'(RAM_NBR_A), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_pct = 100;
        run(2, 1'b0, 1'b0, lat, bcyc);

        // Random lists and random back-pressure, incl. address wrap
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 512; i++) mem[i] = $urandom;
            for (int i = 0; i < 512; i += 37) mem[i] = mem[i] & 32'hFFFF_FFF0;
            rdy_pct = $urandom_range(30, 100);
            run((r == 0) ? 60 : $urandom_range(1, 60), 1'b0, r == 1, lat, bcyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
